dmem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous data/instruction SRAM (1-cycle read latency) between two requesters.
  - Port I: instruction fetch.
  - Port D: the memory stage load/store path.
- Valid/ready request handshake on each port and a valid/ready response per port.
- Port D has fixed priority; an anti-starvation counter guarantees fetch progress.
- One access in flight at a time, sequenced by a 3-state FSM.

---
 rtl/dmem_port_arbiter_if.sv | 46 ++++
 rtl/dmem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Request/response and SRAM bus bundle for the shared data/instruction memory port.
// The slave view belongs to the arbiter; the master view to requesters plus the SRAM.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_valid;
    logic              i_ready;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rsp_valid;
    logic              i_rsp_ready;
    logic [31:0]       i_rsp_data;

    logic              d_valid;
    logic              d_ready;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [3:0]        d_wstrb;
    logic [31:0]       d_wdata;
    logic              d_rsp_valid;
    logic              d_rsp_ready;
    logic [31:0]       d_rsp_data;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_valid, i_addr, i_rsp_ready,
        input  d_valid, d_addr, d_we, d_wstrb, d_wdata, d_rsp_ready,
        input  mem_rdata,
        output i_ready, i_rsp_valid, i_rsp_data,
        output d_ready, d_rsp_valid, d_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_valid, i_addr, i_rsp_ready,
        output d_valid, d_addr, d_we, d_wstrb, d_wdata, d_rsp_ready,
        output mem_rdata,
        input  i_ready, i_rsp_valid, i_rsp_data,
        input  d_ready, d_rsp_valid, d_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates one single-ported SRAM between instruction fetch (I) and load/store (D).
// D has fixed priority; a saturating starvation counter forces an I grant.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
    localparam logic [3:0] STARVE_MAX_C = 4'd15;

    state_t      state_r;
    state_t      state_nxt_s;
    owner_t      owner_r;
    logic        owner_store_r;
    logic [3:0]  starve_cnt_r;
    logic [31:0] rsp_data_r;

    logic        rsp_vis_s;
    logic        hs_s;
    logic        window_s;
    logic        grant_i_s;
    logic        grant_d_s;

    // Arbitration, issue strobes, response outputs and next state
    always_comb begin
        state_nxt_s     = state_r;
        bus.i_ready     = 1'b0;
        bus.d_ready     = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 4'd0;
        bus.mem_addr    = {ADDR_W{1'b0}};
        bus.mem_wdata   = 32'd0;
        bus.i_rsp_valid = 1'b0;
        bus.d_rsp_valid = 1'b0;
        bus.i_rsp_data  = 32'd0;
        bus.d_rsp_data  = 32'd0;

        rsp_vis_s = (state_r == ST_RESP);
        if (owner_r == OWN_D) begin
            hs_s = rsp_vis_s & bus.d_rsp_ready;
        end else begin
            hs_s = rsp_vis_s & bus.i_rsp_ready;
        end

        // A new access may start from IDLE or on the cycle the pending response retires
        window_s  = ~rst & ((state_r == ST_IDLE) | hs_s);
        grant_i_s = window_s & bus.i_valid & (~bus.d_valid | (starve_cnt_r >= STARVE_LIM_C));
        grant_d_s = window_s & bus.d_valid & ~grant_i_s;

        if (rsp_vis_s) begin
            if (owner_r == OWN_D) begin
                bus.d_rsp_valid = 1'b1;
                bus.d_rsp_data  = rsp_data_r;
            end else begin
                bus.i_rsp_valid = 1'b1;
                bus.i_rsp_data  = rsp_data_r;
            end
        end else begin
            bus.i_rsp_valid = 1'b0;
            bus.d_rsp_valid = 1'b0;
        end

        if (grant_i_s) begin
            bus.i_ready  = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.i_addr;
        end else if (grant_d_s) begin
            bus.d_ready   = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.d_addr;
            bus.mem_we    = bus.d_we ? bus.d_wstrb : 4'd0;
            bus.mem_wdata = bus.d_wdata;
        end else begin
            bus.mem_en = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (grant_i_s | grant_d_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (grant_i_s | grant_d_s) begin
                    state_nxt_s = ST_ACCESS;
                end else if (hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and ownership of the access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            owner_r       <= OWN_D;
            owner_store_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_i_s) begin
                owner_r       <= OWN_I;
                owner_store_r <= 1'b0;
            end else if (grant_d_s) begin
                owner_r       <= OWN_D;
                owner_store_r <= bus.d_we;
            end else begin
                owner_r       <= owner_r;
                owner_store_r <= owner_store_r;
            end
        end
    end

    // Capture the SRAM read word (stores return a zero ack word)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_r <= 32'd0;
        end else if (state_r == ST_ACCESS) begin
            rsp_data_r <= owner_store_r ? 32'd0 : bus.mem_rdata;
        end else begin
            rsp_data_r <= rsp_data_r;
        end
    end

    // Counts cycles fetch waits while requesting, saturating at 15
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_i_s) begin
            starve_cnt_r <= 4'd0;
        end else if (bus.i_valid && (starve_cnt_r != STARVE_MAX_C)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic, each cycle
// compared against a timestamp-based transaction model with a shadow memory.
module tb_dmem_port_arbiter;

    localparam int LIM = 4;

    logic clk;
    logic rst;

    dmem_port_arbiter_if #(.ADDR_W(32)) bus ();

    dmem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h0000_0013;
        if (i == 16) return 32'h1122_3344;
        return {16'hC0DE, 16'(i)};
    endfunction

    // SRAM with one-cycle read latency; fills itself on its first clock
    logic [31:0] sram [0:1023];
    logic        sram_ready = 1'b0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
            sram_ready <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we == 4'd0) bus.mem_rdata <= sram[bus.mem_addr[11:2]];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) sram[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] shadow [0:1023];
    bit          m_busy;
    int          m_rsp_at;
    bit          m_owner_d;
    logic [31:0] m_data;
    int          m_starve;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit vis, hs, can, gi, gd;
        int idx;
        #1;
        vis = 1'b0; hs = 1'b0; gi = 1'b0; gd = 1'b0;
        if (!rst) begin
            vis = m_busy && (cyc >= m_rsp_at);
            hs  = vis && (m_owner_d ? bus.d_rsp_ready : bus.i_rsp_ready);
            can = !m_busy || hs;
            gi  = can && bus.i_valid && (!bus.d_valid || m_starve >= LIM);
            gd  = can && bus.d_valid && !gi;
        end
        chk("i_ready", 32'(bus.i_ready), 32'(gi));
        chk("d_ready", 32'(bus.d_ready), 32'(gd));
        chk("mem_en", 32'(bus.mem_en), 32'(gi | gd));
        chk("mem_we", 32'(bus.mem_we), (gd && bus.d_we) ? 32'(bus.d_wstrb) : 32'd0);
        chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(vis && !m_owner_d));
        chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(vis && m_owner_d));
        if (vis && m_owner_d)  chk("d_rsp_data", bus.d_rsp_data, m_data);
        if (vis && !m_owner_d) chk("i_rsp_data", bus.i_rsp_data, m_data);
        if (gi) chk("mem_addr_i", bus.mem_addr, bus.i_addr);
        if (gd) chk("mem_addr_d", bus.mem_addr, bus.d_addr);
        if (gd && bus.d_we) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);

        if (rst) begin
            m_busy   = 1'b0;
            m_starve = 0;
        end else begin
            if (hs) m_busy = 1'b0;
            if (gi || gd) begin
                idx       = gi ? int'(bus.i_addr[11:2]) : int'(bus.d_addr[11:2]);
                m_busy    = 1'b1;
                m_rsp_at  = cyc + 2;
                m_owner_d = gd;
                if (gd && bus.d_we) begin
                    m_data = 32'd0;
                    for (int b = 0; b < 4; b++)
                        if (bus.d_wstrb[b]) shadow[idx][8*b +: 8] = bus.d_wdata[8*b +: 8];
                end else begin
                    m_data = shadow[idx];
                end
            end
            if (gi) m_starve = 0;
            else if (bus.i_valid && m_starve < 15) m_starve++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
        m_busy = 1'b0; m_rsp_at = 0; m_owner_d = 1'b1; m_data = 32'd0; m_starve = 0; cyc = 0;
        bus.i_valid = 1'b0; bus.i_addr = 32'd0; bus.i_rsp_ready = 1'b1;
        bus.d_valid = 1'b0; bus.d_addr = 32'd0; bus.d_we = 1'b0; bus.d_wstrb = 4'd0;
        bus.d_wdata = 32'd0; bus.d_rsp_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b1; bus.d_valid = 1'b1;
        cycle();
        cycle();
        bus.i_valid = 1'b0; bus.d_valid = 1'b0;
        rst = 1'b0;
        cycle();

        // Single fetch
        bus.i_valid = 1'b1; bus.i_addr = 32'h100;
        cycle();
        bus.i_valid = 1'b0;
        cycle();
        #1 chk("fetch_data", bus.i_rsp_data, 32'h0000_0013);
        chk("fetch_valid", 32'(bus.i_rsp_valid), 32'd1);
        cycle();
        cycle();

        // Simultaneous requests: D first, I on the handshake cycle
        bus.i_valid = 1'b1; bus.i_addr = 32'h104;
        bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        cycle();
        bus.d_valid = 1'b0;
        cycle();
        cycle();
        bus.i_valid = 1'b0;
        repeat (4) cycle();

        // D saturating the port while I keeps asking
        bus.i_valid = 1'b1; bus.d_valid = 1'b1; bus.d_we = 1'b0;
        for (int k = 0; k < 14; k++) begin
            bus.d_addr = {20'd0, 10'($urandom), 2'b00};
            cycle();
        end
        bus.i_valid = 1'b0; bus.d_valid = 1'b0;
        repeat (4) cycle();

        // Partial store then reload
        bus.d_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40;
        bus.d_wstrb = 4'b0011; bus.d_wdata = 32'hAABB_CCDD;
        cycle();
        bus.d_valid = 1'b0;
        cycle();
        cycle();
        bus.d_valid = 1'b1; bus.d_we = 1'b0;
        cycle();
        bus.d_valid = 1'b0;
        cycle();
        #1 chk("reload_40", bus.d_rsp_data, 32'h1122_CCDD);
        cycle();
        cycle();

        // Response backpressure with fetch waiting
        bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80; bus.d_rsp_ready = 1'b0;
        cycle();
        bus.d_valid = 1'b0; bus.i_valid = 1'b1; bus.i_addr = 32'h100;
        repeat (6) cycle();
        bus.d_rsp_ready = 1'b1;
        cycle();
        bus.i_valid = 1'b0;
        repeat (4) cycle();

        // Reset during ACCESS discards the access
        bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        cycle();
        bus.d_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        bus.d_valid = 1'b1; bus.d_addr = 32'h48;
        cycle();
        bus.d_valid = 1'b0;
        repeat (4) cycle();

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            bus.i_valid     = ($urandom % 3) != 0;
            bus.i_addr      = {20'd0, 10'($urandom), 2'b00};
            bus.d_valid     = ($urandom % 2) != 0;
            bus.d_addr      = {20'd0, 4'($urandom), 6'd0, 2'b00};
            bus.d_we        = ($urandom % 2) != 0;
            bus.d_wstrb     = 4'($urandom);
            bus.d_wdata     = $urandom;
            bus.i_rsp_ready = ($urandom % 4) != 0;
            bus.d_rsp_ready = ($urandom % 4) != 0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
